// File: rtl/dpic_mem_arbiter.sv
// Two-port (IF read-only, LS read/write) arbiter/sequencer for the single-port DPI-C memory model.
// Optional round-robin arbitration via `define DPIC_MEM_ARB_RR_EN; default is fixed LS-over-IF priority.
module dpic_mem_arbiter #(
   parameter int AW = 64,
   parameter int DW = 64,
   parameter int MW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req_valid,
   output logic          if_req_ready,
   input  logic [AW-1:0] if_req_addr,
   output logic          if_resp_valid,
   input  logic          if_resp_ready,
   output logic [DW-1:0] if_resp_data,
   input  logic          ls_req_valid,
   output logic          ls_req_ready,
   input  logic [AW-1:0] ls_req_addr,
   input  logic          ls_req_we,
   input  logic [DW-1:0] ls_req_wdata,
   input  logic [MW-1:0] ls_req_wmask,
   output logic          ls_resp_valid,
   input  logic          ls_resp_ready,
   output logic [DW-1:0] ls_resp_data,
   output logic          ls_resp_err,
   output logic          mem_rd_en,
   output logic [AW-1:0] mem_rd_addr,
   input  logic [DW-1:0] mem_rd_data,
   output logic          mem_we_en,
   output logic [AW-1:0] mem_we_addr,
   output logic [DW-1:0] mem_we_data,
   output logic [MW-1:0] mem_we_mask
);

   typedef enum logic [2:0] {IDLE, READ, DATA, WRITE, RESP} state_t;

   typedef struct packed {
      logic          ls;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [MW-1:0] wmask;
   } req_t;

   state_t state, state_nxt;
   req_t   req_q;
   logic   idle, if_acc, ls_acc, resp_hs, mask_ok;

   assign idle    = (state == IDLE);
   assign if_acc  = if_req_valid & if_req_ready;
   assign ls_acc  = ls_req_valid & ls_req_ready;
   assign resp_hs = (if_resp_valid & if_resp_ready) | (ls_resp_valid & ls_resp_ready);
   assign mask_ok = (req_q.wmask == MW'(8'h01)) || (req_q.wmask == MW'(8'h03)) ||
                    (req_q.wmask == MW'(8'h0F)) || (req_q.wmask == MW'(8'hFF));

`ifdef DPIC_MEM_ARB_RR_EN
   // last_ls = 1 when LS was granted last; a tie goes to the other port
   logic last_ls;

   assign if_req_ready = idle & (~ls_req_valid | last_ls);
   assign ls_req_ready = idle & (~if_req_valid | ~last_ls);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  last_ls <= 1'b0;
      else if (if_acc | ls_acc)  last_ls <= ls_acc;
   end
`else
   assign if_req_ready = idle & ~ls_req_valid;
   assign ls_req_ready = idle;
`endif

   assign mem_rd_en   = (state == READ);
   assign mem_we_en   = (state == WRITE) & mask_ok;
   assign mem_we_addr = mem_we_en ? req_q.addr  : '0;
   assign mem_we_data = mem_we_en ? req_q.wdata : '0;
   assign mem_we_mask = mem_we_en ? req_q.wmask : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (ls_acc)      state_nxt = ls_req_we ? WRITE : READ;
            else if (if_acc) state_nxt = READ;
         end
         READ:    state_nxt = DATA;
         DATA:    state_nxt = RESP;
         WRITE:   state_nxt = RESP;
         RESP:    if (resp_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_q         <= '0;
         mem_rd_addr   <= '0;
         if_resp_data  <= '0;
         ls_resp_data  <= '0;
         ls_resp_err   <= 1'b0;
         if_resp_valid <= 1'b0;
         ls_resp_valid <= 1'b0;
      end else begin
         if (if_acc | ls_acc) begin
            req_q.ls    <= ls_acc;
            req_q.we    <= ls_acc & ls_req_we;
            req_q.addr  <= ls_acc ? ls_req_addr : if_req_addr;
            req_q.wdata <= ls_req_wdata;
            req_q.wmask <= ls_req_wmask;
            ls_resp_err <= 1'b0;
            // read address is only moved by reads so the free-running memory read stays put
            if (!(ls_acc & ls_req_we))
               mem_rd_addr <= ls_acc ? ls_req_addr : if_req_addr;
         end
         if (state == DATA) begin
            if (req_q.ls) ls_resp_data <= mem_rd_data;
            else          if_resp_data <= mem_rd_data;
         end
         if (state == WRITE) begin
            ls_resp_data <= '0;
            ls_resp_err  <= ~mask_ok;
         end
         // valid rises one cycle into RESP and drops on the edge that sees the handshake
         if_resp_valid <= (state == RESP) & ~req_q.ls & ~(if_resp_valid & if_resp_ready);
         ls_resp_valid <= (state == RESP) &  req_q.ls & ~(ls_resp_valid & ls_resp_ready);
      end
   end

endmodule
